// File: rtl/load_ctrl_pkg.sv
// Shared load definitions: funct3 encodings, LOAD opcode, sequencer states
// and the accept-time legality check used by the load sequencer.
package load_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2,
        FLT  = 2'd3
    } load_state_t;

    // True when the load can never be issued: unknown width or misaligned address.
    function automatic logic load_fault(input logic [2:0] f3, input logic [1:0] ea_lo);
        logic f;
        case (f3)
            OP_LB, OP_LBU: f = 1'b0;
            OP_LH, OP_LHU: f = ea_lo[0];
            OP_LW:         f = (ea_lo != 2'b00);
            default:       f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/load_align.sv
// Lane select and sign/zero extension of a 32-bit read word into an XLEN result.
module load_align
    import load_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     rdata,
    input  logic [1:0]      ea_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed byte/half and extend according to the load flavour.
    always_comb begin
        byte_v = rdata[{ea_lo, 3'b000} +: 8];
        half_v = rdata[{ea_lo[1], 4'b0000} +: 16];
        case (funct3)
            OP_LB:   result = XLEN'($signed(byte_v));
            OP_LBU:  result = XLEN'(byte_v);
            OP_LH:   result = XLEN'($signed(half_v));
            OP_LHU:  result = XLEN'(half_v);
            OP_LW:   result = XLEN'($signed(rdata));
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_ctrl.sv
// Load sequencer: address generation, legality check, memory handshake with
// timeout, lane extraction and one-cycle register-file writeback.
//
//   state | meaning
//   IDLE  | waiting for start; latches ea/funct3/rd on accept
//   REQ   | mem_req high, waiting for mem_ready, counting toward timeout
//   WB    | done pulse, writeback unless rd is x0
//   FLT   | done + fault pulse (misaligned, illegal funct3 or timeout)
module load_ctrl
    import load_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd_idx,
    input  logic [XLEN-1:0] base,
    input  logic [11:0]     imm12,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ready,
    input  logic [31:0]     mem_rdata,
    output logic            busy,
    output logic            done,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            fault,
    output logic [XLEN-1:0] fault_addr
);

    localparam int             CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    load_state_t     state_q, state_d;
    logic [XLEN-1:0] ea_q, ea_d;
    logic [2:0]      f3_q, f3_d;
    logic [4:0]      rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] ea_new;
    logic [XLEN-1:0] align_data;

    load_align #(.XLEN(XLEN)) u_align (
        .rdata  (mem_rdata),
        .ea_lo  (ea_q[1:0]),
        .funct3 (f3_q),
        .result (align_data)
    );

    // Next-state logic: accept, handshake with timeout, single-cycle completion.
    always_comb begin
        state_d   = state_q;
        ea_d      = ea_q;
        f3_d      = f3_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;
        ea_new    = base + XLEN'($signed(imm12));
        case (state_q)
            IDLE: begin
                if (start) begin
                    ea_d    = ea_new;
                    f3_d    = funct3;
                    rd_d    = rd_idx;
                    cnt_d   = '0;
                    state_d = load_fault(funct3, ea_new[1:0]) ? FLT : REQ;
                end
            end
            REQ: begin
                // Ready on the last permitted cycle still completes normally.
                if (mem_ready) begin
                    wb_data_d = align_data;
                    wb_rd_d   = rd_q;
                    state_d   = WB;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = FLT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WB:      state_d = IDLE;
            FLT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q   <= IDLE;
            ea_q      <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            wb_data_q <= '0;
            wb_rd_q   <= '0;
        end else begin
            state_q   <= state_d;
            ea_q      <= ea_d;
            f3_q      <= f3_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
        end
    end

    assign mem_req    = (state_q == REQ);
    assign mem_addr   = {ea_q[XLEN-1:2], 2'b00};
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == WB) || (state_q == FLT);
    assign wb_en      = (state_q == WB) && (rd_q != 5'd0);
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign fault      = (state_q == FLT);
    assign fault_addr = ea_q;

endmodule

// File: tb/tb_load_ctrl.sv
// Self-checking bench for load_ctrl: directed cases plus randomized loads
// checked against an arithmetic reference model of RV32I load semantics.
module tb_load_ctrl;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 16;

    logic            CLK = 1'b0;
    logic            reset;
    logic            start;
    logic [2:0]      funct3;
    logic [4:0]      rd_idx;
    logic [XLEN-1:0] base;
    logic [11:0]     imm12;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ready;
    logic [31:0]     mem_rdata;
    logic            busy;
    logic            done;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            fault;
    logic [XLEN-1:0] fault_addr;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_wb_data = '0;
    logic [4:0]  exp_wb_rd   = '0;

    load_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .start      (start),
        .funct3     (funct3),
        .rd_idx     (rd_idx),
        .base       (base),
        .imm12      (imm12),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .fault      (fault),
        .fault_addr (fault_addr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Reference: is this load illegal at accept time?
    function automatic bit model_fault(input logic [2:0] f3, input logic [31:0] ea);
        int a;
        a = int'(ea % 4);
        case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return (a % 2) != 0;
            3'd2:       return a != 0;
            default:    return 1'b1;
        endcase
    endfunction

    // Reference: extended load value from a word using shifts and arithmetic.
    function automatic logic [31:0] model_data(input logic [2:0] f3, input logic [31:0] ea,
                                               input logic [31:0] word);
        logic [31:0] sh;
        int          v;
        case (f3)
            3'd0, 3'd4: begin
                sh = word >> (8 * (ea % 4));
                v  = int'(sh % 256);
                if (f3 == 3'd0 && v >= 128) v = v - 256;
            end
            3'd1, 3'd5: begin
                sh = word >> (16 * ((ea % 4) / 2));
                v  = int'(sh % 65536);
                if (f3 == 3'd1 && v >= 32768) v = v - 65536;
            end
            default: v = int'(word);
        endcase
        return 32'(v);
    endfunction

    // One load from an idle cycle through the first idle cycle after completion.
    // wait_n = number of non-ready request cycles before ready (>= TIMEOUT: never).
    task automatic do_load(input string nm, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] b, input logic [11:0] imm,
                           input logic [31:0] word, input int wait_n, input bit poke);
        logic [31:0] ea;
        bit          flt;
        bit          got;
        ea  = b + {{20{imm[11]}}, imm};
        flt = model_fault(f3, ea);
        got = 1'b0;
        chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
        start     = 1'b1;
        funct3    = f3;
        rd_idx    = rd;
        base      = b;
        imm12     = imm;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        tick;
        start     = 1'b0;
        base      = $urandom;
        imm12     = 12'($urandom);
        funct3    = 3'($urandom);
        rd_idx    = 5'($urandom);
        mem_ready = 1'b0;
        if (flt) begin
            chk({nm, "_acc_done"},   32'(done),    32'd1);
            chk({nm, "_acc_fault"},  32'(fault),   32'd1);
            chk({nm, "_acc_faddr"},  fault_addr,   ea);
            chk({nm, "_acc_memreq"}, 32'(mem_req), 32'd0);
            chk({nm, "_acc_wben"},   32'(wb_en),   32'd0);
        end else begin
            for (int k = 0; k < TIMEOUT; k++) begin
                chk({nm, "_req"},   32'(mem_req), 32'd1);
                chk({nm, "_addr"},  mem_addr,     ea & 32'hFFFF_FFFC);
                chk({nm, "_nodone"}, 32'(done),   32'd0);
                mem_ready = (k == wait_n);
                mem_rdata = mem_ready ? word : $urandom;
                if (poke && k == 0) begin
                    start  = 1'b1;
                    funct3 = 3'b011;
                end
                tick;
                start     = 1'b0;
                mem_ready = 1'b0;
                if (k == wait_n) begin
                    got = 1'b1;
                    break;
                end
            end
            chk({nm, "_done"},   32'(done),    32'd1);
            chk({nm, "_memreq"}, 32'(mem_req), 32'd0);
            if (got) begin
                exp_wb_data = model_data(f3, ea, word);
                exp_wb_rd   = rd;
                chk({nm, "_fault"}, 32'(fault), 32'd0);
                chk({nm, "_wben"},  32'(wb_en), 32'(rd != 5'd0));
            end else begin
                chk({nm, "_to_fault"}, 32'(fault), 32'd1);
                chk({nm, "_to_faddr"}, fault_addr,  ea);
                chk({nm, "_to_wben"},  32'(wb_en),  32'd0);
            end
        end
        chk({nm, "_wbdata"}, wb_data,     exp_wb_data);
        chk({nm, "_wbrd"},   32'(wb_rd),  32'(exp_wb_rd));
        tick;
        chk({nm, "_post_done"}, 32'(done),  32'd0);
        chk({nm, "_post_busy"}, 32'(busy),  32'd0);
        chk({nm, "_post_wben"}, 32'(wb_en), 32'd0);
        chk({nm, "_hold_data"}, wb_data,    exp_wb_data);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_memreq"}, 32'(mem_req), 32'd0);
        chk({nm, "_addr"},   mem_addr,     32'd0);
        chk({nm, "_busy"},   32'(busy),    32'd0);
        chk({nm, "_done"},   32'(done),    32'd0);
        chk({nm, "_wben"},   32'(wb_en),   32'd0);
        chk({nm, "_wbrd"},   32'(wb_rd),   32'd0);
        chk({nm, "_wbdata"}, wb_data,      32'd0);
        chk({nm, "_fault"},  32'(fault),   32'd0);
        chk({nm, "_faddr"},  fault_addr,   32'd0);
    endtask

    initial begin
        logic [2:0]  legal [5];
        logic [2:0]  f3;
        logic [31:0] b;
        logic [31:0] ea;
        logic [11:0] imm;
        legal[0] = 3'd0; legal[1] = 3'd1; legal[2] = 3'd2; legal[3] = 3'd4; legal[4] = 3'd5;

        reset = 1'b0; start = 1'b0; funct3 = '0; rd_idx = '0; base = '0; imm12 = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        tick; tick; tick;
        chk_all_zero("rst");
        reset = 1'b1;
        tick;

        do_load("lb",      3'd0, 5'd3,  32'h100, 12'h003, 32'h80FF_1234, 0, 1'b0);
        do_load("lhu",     3'd5, 5'd4,  32'h200, 12'hFFE, 32'hBEEF_0000, 3, 1'b0);
        do_load("lw_mis",  3'd2, 5'd5,  32'h100, 12'h002, 32'h0,         0, 1'b0);
        do_load("f3_011",  3'd3, 5'd6,  32'h100, 12'h000, 32'h0,         0, 1'b0);
        do_load("timeout", 3'd2, 5'd7,  32'h400, 12'h010, 32'h0,         TIMEOUT, 1'b0);
        do_load("rdy_last",3'd2, 5'd8,  32'h400, 12'h010, 32'hCAFE_F00D, TIMEOUT - 1, 1'b0);
        do_load("x0",      3'd1, 5'd0,  32'h300, 12'h002, 32'h8001_7FFF, 1, 1'b0);
        do_load("poke",    3'd4, 5'd9,  32'h300, 12'h001, 32'h1234_A5C3, 2, 1'b1);

        // Reset asserted in the second request cycle aborts the load silently.
        chk("ab_idle", 32'(busy), 32'd0);
        start = 1'b1; funct3 = 3'd2; rd_idx = 5'd10; base = 32'h500; imm12 = 12'h0;
        tick;
        start = 1'b0;
        chk("ab_req1", 32'(mem_req), 32'd1);
        tick;
        chk("ab_req2", 32'(mem_req), 32'd1);
        reset = 1'b0;
        tick;
        reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
        exp_wb_data = '0;
        exp_wb_rd   = '0;
        chk_all_zero("ab_rst");
        tick;
        chk_all_zero("ab_after");
        mem_ready = 1'b0;
        tick;
        chk("ab_quiet_done", 32'(done), 32'd0);

        for (int i = 0; i < 40; i++) begin
            f3  = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 4)] : 3'($urandom);
            b   = $urandom;
            imm = 12'($urandom);
            ea  = b + {{20{imm[11]}}, imm};
            if ($urandom_range(0, 3) != 0) b = b - (ea & 32'h3);
            do_load($sformatf("rnd%0d", i), f3, 5'($urandom), b, imm, $urandom,
                    $urandom_range(0, 20), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
